// File: rtl/safe_pkg.sv
// Shared defaults and serializer state encoding for the code-lock slice.
package safe_pkg;

    localparam int          N_DEF    = 4;
    localparam logic [3:0]  CODE_DEF = 4'd11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

endpackage

// File: rtl/safe_piso.sv
// Parallel-in serial-out shifter with valid/ready on both sides, LSB first.
module safe_piso
    import safe_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pdata,
    input  logic         pvalid,
    output logic         pready,
    input  logic         sready,
    output logic         sdata,
    output logic         svalid
);

    localparam int CW = $clog2(N);

    piso_state_e   state_q, state_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pvalid) begin
                    state_d = SHIFT;
                    sreg_d  = pdata;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // Stalls indefinitely while the downstream holds sready low.
                if (sready) begin
                    sreg_d = sreg_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pready = (state_q == IDLE);
        svalid = (state_q == SHIFT);
        sdata  = sreg_q[0];
    end

endmodule

// File: rtl/safe_top.sv
// Code lock: serializes the entered word and judges the bits seen on the serial link.
module safe_top
    import safe_pkg::*;
#(
    parameter int         N    = N_DEF,
    parameter logic [N-1:0] CODE = N'(CODE_DEF)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pdata,
    input  logic         pvalid,
    output logic         pready,
    input  logic         sready,
    output logic         sdata,
    output logic         svalid,
    output logic         unlock_valid,
    output logic         unlock,
    output logic         incorrect
);

    localparam int CW = $clog2(N);

    logic          xfer;
    logic          last_xfer;
    logic [N-1:0]  word_q, word_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          uv_q, unlock_q, incorrect_q;

    safe_piso #(.N(N)) u_piso (
        .clk    (clk),
        .rst    (rst),
        .pdata  (pdata),
        .pvalid (pvalid),
        .pready (pready),
        .sready (sready),
        .sdata  (sdata),
        .svalid (svalid)
    );

    // The checker tracks the link independently of the serializer's own counter.
    always_comb begin
        xfer      = svalid && sready;
        last_xfer = xfer && (cnt_q == CW'(N - 1));
        word_d    = xfer ? {sdata, word_q[N-1:1]} : word_q;
        cnt_d     = cnt_q;
        if (last_xfer) begin
            cnt_d = '0;
        end else if (xfer) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q      <= '0;
            cnt_q       <= '0;
            uv_q        <= 1'b0;
            unlock_q    <= 1'b0;
            incorrect_q <= 1'b0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            uv_q   <= last_xfer;
            if (last_xfer) begin
                unlock_q    <= (word_d == CODE);
                incorrect_q <= (word_d != CODE);
            end
        end
    end

    assign unlock_valid = uv_q;
    assign unlock       = unlock_q;
    assign incorrect    = incorrect_q;

endmodule

// File: tb/tb_safe_top.sv
// Directed self-checking bench for safe_top with the default 4-bit code 11.
module tb_safe_top;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pdata;
    logic       pvalid;
    logic       pready;
    logic       sready;
    logic       sdata;
    logic       svalid;
    logic       unlock_valid;
    logic       unlock;
    logic       incorrect;

    int n_tests = 0;
    int n_fail  = 0;

    safe_top dut (
        .clk          (clk),
        .rst          (rst),
        .pdata        (pdata),
        .pvalid       (pvalid),
        .pready       (pready),
        .sready       (sready),
        .sdata        (sdata),
        .svalid       (svalid),
        .unlock_valid (unlock_valid),
        .unlock       (unlock),
        .incorrect    (incorrect)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, ".pready"},       32'(pready),       32'd1);
        chk({tag, ".svalid"},       32'(svalid),       32'd0);
        chk({tag, ".sdata"},        32'(sdata),        32'd0);
        chk({tag, ".unlock_valid"}, 32'(unlock_valid), 32'd0);
        chk({tag, ".unlock"},       32'(unlock),       32'd0);
        chk({tag, ".incorrect"},    32'(incorrect),    32'd0);
    endtask

    // Sends a word with sready held high; bits and verdict are supplied by the caller.
    task automatic send_word(input string tag, input logic [3:0] w, input logic [3:0] bits,
                             input logic exp_unlock);
        pdata  = w;
        pvalid = 1'b1;
        sready = 1'b1;
        tick();
        pvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, ".svalid"}, 32'(svalid), 32'd1);
            chk({tag, ".pready"}, 32'(pready), 32'd0);
            chk({tag, ".sdata"},  32'(sdata),  32'(bits[i]));
            chk({tag, ".uv_low"}, 32'(unlock_valid), 32'd0);
            tick();
        end
        chk({tag, ".unlock_valid"}, 32'(unlock_valid), 32'd1);
        chk({tag, ".unlock"},       32'(unlock),       32'(exp_unlock));
        chk({tag, ".incorrect"},    32'(incorrect),    32'(!exp_unlock));
        chk({tag, ".pready"},       32'(pready),       32'd1);
        chk({tag, ".svalid_done"},  32'(svalid),       32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        pdata  = 4'd0;
        pvalid = 1'b0;
        sready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_idle_reset("reset");

        // Accept 11 with the downstream stalled: first bit held.
        pdata  = 4'd11;
        pvalid = 1'b1;
        tick();
        pvalid = 1'b0;
        pdata  = 4'd0;
        for (int i = 0; i < 3; i++) begin
            chk("stall.pready", 32'(pready), 32'd0);
            chk("stall.svalid", 32'(svalid), 32'd1);
            chk("stall.sdata",  32'(sdata),  32'd1);
            tick();
        end
        sready = 1'b1;
        chk("w11.b0", 32'(sdata), 32'd1);
        tick();
        chk("w11.b1", 32'(sdata), 32'd1);
        tick();
        chk("w11.b2", 32'(sdata), 32'd0);
        tick();
        chk("w11.b3", 32'(sdata), 32'd1);
        tick();
        chk("w11.unlock_valid", 32'(unlock_valid), 32'd1);
        chk("w11.unlock",       32'(unlock),       32'd1);
        chk("w11.incorrect",    32'(incorrect),    32'd0);
        chk("w11.pready",       32'(pready),       32'd1);
        tick();
        chk("w11.pulse_end", 32'(unlock_valid), 32'd0);
        chk("w11.hold",      32'(unlock),       32'd1);

        send_word("w12", 4'd12, 4'b1100, 1'b0);
        tick();

        // Back-to-back words: each next word is offered in the previous verdict cycle.
        send_word("seq11", 4'd11, 4'b1011, 1'b1);
        send_word("seq3",  4'd3,  4'b0011, 1'b0);
        tick();
        chk("seq3.hold_uv",  32'(unlock_valid), 32'd0);
        chk("seq3.hold_inc", 32'(incorrect),    32'd1);
        tick();
        chk("seq3.hold_unl", 32'(unlock),       32'd0);
        send_word("seq8",  4'd8,  4'b1000, 1'b0);
        tick();
        chk("seq8.hold_inc", 32'(incorrect), 32'd1);

        // pvalid pulsed mid-word with pdata=0 must be ignored.
        pdata  = 4'd11;
        pvalid = 1'b1;
        sready = 1'b1;
        tick();
        pvalid = 1'b0;
        chk("mid.b0", 32'(sdata), 32'd1);
        tick();
        pdata  = 4'd0;
        pvalid = 1'b1;
        chk("mid.b1", 32'(sdata), 32'd1);
        tick();
        pvalid = 1'b0;
        chk("mid.b2", 32'(sdata), 32'd0);
        chk("mid.pready", 32'(pready), 32'd0);
        tick();
        chk("mid.b3", 32'(sdata), 32'd1);
        tick();
        chk("mid.unlock_valid", 32'(unlock_valid), 32'd1);
        chk("mid.unlock",       32'(unlock),       32'd1);
        tick();
        chk("mid.no_new_word", 32'(svalid), 32'd0);

        // Reset after two of four bits aborts the word with no verdict.
        pdata  = 4'd12;
        pvalid = 1'b1;
        tick();
        pvalid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_reset("abort");
        for (int i = 0; i < 4; i++) begin
            chk("abort.no_verdict", 32'(unlock_valid), 32'd0);
            tick();
        end
        send_word("post", 4'd11, 4'b1011, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
